// File: rtl/bram_debug_sequencer.sv
// -----------------------------------------------------------------------------
// bram_debug_sequencer
//
// Owns the RV32Core debug BRAM ports (*_a2/_wd2/_we2/_rd2) on behalf of a host
// link. A command either loads a stream of 32-bit words into the Data or Inst
// BRAM starting at byte address 0, or dumps BRAM words out as a stream. While
// a command runs, core_hold keeps the core idle. After a load, core_rst is
// pulsed for RST_CYCLES cycles so the core restarts from the fresh image.
//
// Ports
//   CPU_CLK, CPU_RST         clock, synchronous active-high reset
//   cmd_valid/ready/op/sel/count
//                            command handshake (op 0=load 1=dump,
//                            sel 0=Data 1=Inst, count 0 means full depth)
//   in_valid/ready/data      load word stream
//   out_valid/ready/data     dump word stream
//   dram_*2, iram_*2         debug BRAM ports (byte addresses, 1-cycle read)
//   core_hold, core_rst      core control
//   busy, done               status (done is a one-cycle completion pulse)
//
// All outputs come straight from flops. Their next values are derived from
// the next state, so every output changes on the same edge as the state.
// -----------------------------------------------------------------------------
module bram_debug_sequencer #(
   parameter int BRAMWORDS  = 4096,
   parameter int CNT_W      = 13,
   parameter int RST_CYCLES = 5
) (
   input  logic             CPU_CLK,
   input  logic             CPU_RST,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_op,
   input  logic             cmd_sel,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [31:0]      dram_a2,
   output logic [31:0]      dram_wd2,
   output logic [3:0]       dram_we2,
   input  logic [31:0]      dram_rd2,
   output logic [31:0]      iram_a2,
   output logic [31:0]      iram_wd2,
   output logic [3:0]       iram_we2,
   input  logic [31:0]      iram_rd2,
   output logic             core_hold,
   output logic             core_rst,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_DUMP_RD   = 3'd2,
      S_DUMP_WAIT = 3'd3,
      S_DUMP_OUT  = 3'd4,
      S_CORE_RST  = 3'd5
   } state_t;

   localparam int               RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(BRAMWORDS);

   // A zero or oversized count means "the whole BRAM"; this also keeps the
   // byte address from ever passing (BRAMWORDS-1)*4.
   function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
      logic [CNT_W-1:0] r;
      if ((c == {CNT_W{1'b0}}) || (c > MAX_CNT)) begin
         r = MAX_CNT;
      end else begin
         r = c;
      end
      return r;
   endfunction

   state_t           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sel_q, sel_d;
   logic [RC_W-1:0]  rc_q, rc_d;

   logic             cmd_ready_q, cmd_ready_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [31:0]      out_data_q, out_data_d;
   logic [31:0]      dram_a2_q, dram_a2_d, dram_wd2_q, dram_wd2_d;
   logic [3:0]       dram_we2_q, dram_we2_d;
   logic [31:0]      iram_a2_q, iram_a2_d, iram_wd2_q, iram_wd2_d;
   logic [3:0]       iram_we2_q, iram_we2_d;
   logic             core_hold_q, core_hold_d;
   logic             core_rst_q, core_rst_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // State register and datapath counters.
   always_ff @(posedge CPU_CLK) begin
      if (CPU_RST) begin
         state_q <= S_IDLE;
         addr_q  <= 32'd0;
         cnt_q   <= {CNT_W{1'b0}};
         sel_q   <= 1'b0;
         rc_q    <= {RC_W{1'b0}};
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         rc_q    <= rc_d;
      end
   end

   // Next-state logic: command accept, per-word address/count stepping.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      rc_d    = rc_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               addr_d  = 32'd0;
               cnt_d   = clamp_count(cmd_count);
               sel_d   = cmd_sel;
               state_d = cmd_op ? S_DUMP_RD : S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               addr_d = addr_q + 32'd4;
               cnt_d  = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_CORE_RST;
                  rc_d    = RC_W'(RST_CYCLES - 1);
               end else begin
                  state_d = S_LOAD;
               end
            end else begin
               state_d = S_LOAD;
            end
         end
         S_CORE_RST: begin
            if (rc_q == {RC_W{1'b0}}) begin
               state_d = S_IDLE;
            end else begin
               rc_d = rc_q - RC_W'(1);
            end
         end
         S_DUMP_RD:   state_d = S_DUMP_WAIT;
         S_DUMP_WAIT: state_d = S_DUMP_OUT;
         S_DUMP_OUT: begin
            if (out_ready) begin
               addr_d  = addr_q + 32'd4;
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = (cnt_q == CNT_W'(1)) ? S_IDLE : S_DUMP_RD;
            end else begin
               state_d = S_DUMP_OUT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs.
   always_comb begin
      logic        load_wr;
      logic [31:0] ram_a;
      logic [31:0] ram_wd;
      logic [3:0]  ram_we;
      load_wr = (state_q == S_LOAD) && in_valid;
      ram_a   = 32'd0;
      ram_wd  = 32'd0;
      ram_we  = 4'h0;
      if (load_wr) begin
         // The write lands one cycle after the handshake, at the pre-increment address.
         ram_a  = addr_q;
         ram_wd = in_data;
         ram_we = 4'hF;
      end else if (state_d == S_DUMP_RD) begin
         ram_a  = addr_d;
      end else begin
         ram_a  = 32'd0;
      end
      // Only the selected BRAM sees activity; the other port is held at zero.
      dram_a2_d  = sel_d ? 32'd0 : ram_a;
      dram_wd2_d = sel_d ? 32'd0 : ram_wd;
      dram_we2_d = sel_d ? 4'h0  : ram_we;
      iram_a2_d  = sel_d ? ram_a  : 32'd0;
      iram_wd2_d = sel_d ? ram_wd : 32'd0;
      iram_we2_d = sel_d ? ram_we : 4'h0;
      // rd2 is valid in DUMP_WAIT (address was presented in DUMP_RD).
      if (state_q == S_DUMP_WAIT) begin
         out_data_d = sel_q ? iram_rd2 : dram_rd2;
      end else begin
         out_data_d = out_data_q;
      end
      cmd_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
      core_hold_d = (state_d != S_IDLE);
      core_rst_d  = (state_d == S_CORE_RST);
      in_ready_d  = (state_d == S_LOAD);
      out_valid_d = (state_d == S_DUMP_OUT);
      done_d      = (state_q != S_IDLE) && (state_d == S_IDLE);
   end

   // Output registers; a reset drops any pending write and in-flight dump word.
   always_ff @(posedge CPU_CLK) begin
      if (CPU_RST) begin
         cmd_ready_q <= 1'b1;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'd0;
         dram_a2_q   <= 32'd0;
         dram_wd2_q  <= 32'd0;
         dram_we2_q  <= 4'h0;
         iram_a2_q   <= 32'd0;
         iram_wd2_q  <= 32'd0;
         iram_we2_q  <= 4'h0;
         core_hold_q <= 1'b0;
         core_rst_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         cmd_ready_q <= cmd_ready_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         dram_a2_q   <= dram_a2_d;
         dram_wd2_q  <= dram_wd2_d;
         dram_we2_q  <= dram_we2_d;
         iram_a2_q   <= iram_a2_d;
         iram_wd2_q  <= iram_wd2_d;
         iram_we2_q  <= iram_we2_d;
         core_hold_q <= core_hold_d;
         core_rst_q  <= core_rst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign dram_a2   = dram_a2_q;
   assign dram_wd2  = dram_wd2_q;
   assign dram_we2  = dram_we2_q;
   assign iram_a2   = iram_a2_q;
   assign iram_wd2  = iram_wd2_q;
   assign iram_we2  = iram_we2_q;
   assign core_hold = core_hold_q;
   assign core_rst  = core_rst_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_bram_debug_sequencer.sv
// Bench for bram_debug_sequencer: behavioural BRAMs with a write log, a
// shadow array of expected memory contents, and per-scenario tasks.
module tb_bram_debug_sequencer;

   typedef logic [31:0] wq_t[$];
   typedef struct packed {
      logic [31:0] cyc;
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   logic        CPU_CLK = 1'b0;
   logic        CPU_RST = 1'b1;
   logic        cmd_valid = 1'b0, cmd_op = 1'b0, cmd_sel = 1'b0;
   logic [12:0] cmd_count = 13'd0;
   logic        cmd_ready;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [31:0] dram_a2, dram_wd2, iram_a2, iram_wd2;
   logic [3:0]  dram_we2, iram_we2;
   logic [31:0] dram_rd2, iram_rd2;
   logic        core_hold, core_rst, busy, done;

   int checks = 0;
   int errors = 0;

   // BRAM models and activity monitors.
   logic [31:0] dram_mem[4096];
   logic [31:0] iram_mem[4096];
   logic [31:0] exp_dram[4096];
   logic [31:0] exp_iram[4096];
   logic        init_go = 1'b0;
   logic        pre_we = 1'b0;
   logic [11:0] pre_idx = 12'd0;
   logic [31:0] pre_data = 32'd0;
   logic [31:0] cyc = 32'd0;
   wr_t         dram_wr_q[$];
   wr_t         iram_wr_q[$];
   logic [31:0] hs_cyc_q[$];
   int          core_rst_cycles = 0;
   int          done_count = 0;
   int          out_valid_cycles = 0;
   logic [31:0] last_dram_a2 = 32'd0;

   always #5 CPU_CLK = ~CPU_CLK;

   bram_debug_sequencer dut (
      .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_sel(cmd_sel), .cmd_count(cmd_count),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .dram_a2(dram_a2), .dram_wd2(dram_wd2), .dram_we2(dram_we2), .dram_rd2(dram_rd2),
      .iram_a2(iram_a2), .iram_wd2(iram_wd2), .iram_we2(iram_we2), .iram_rd2(iram_rd2),
      .core_hold(core_hold), .core_rst(core_rst), .busy(busy), .done(done)
   );

   always @(posedge CPU_CLK) begin
      cyc <= cyc + 32'd1;
      if (init_go) begin
         for (int i = 0; i < 4096; i++) begin
            dram_mem[i] <= 32'hD000_0000 | i;
            iram_mem[i] <= 32'h1000_0000 | i;
         end
      end else if (pre_we) begin
         iram_mem[pre_idx] <= pre_data;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (dram_we2[b]) dram_mem[dram_a2[13:2]][8*b +: 8] <= dram_wd2[8*b +: 8];
            if (iram_we2[b]) iram_mem[iram_a2[13:2]][8*b +: 8] <= iram_wd2[8*b +: 8];
         end
      end
      dram_rd2 <= dram_mem[dram_a2[13:2]];
      iram_rd2 <= iram_mem[iram_a2[13:2]];
      if (dram_we2 != 4'h0) dram_wr_q.push_back({cyc, dram_a2, dram_wd2});
      if (iram_we2 != 4'h0) iram_wr_q.push_back({cyc, iram_a2, iram_wd2});
      if (in_valid && in_ready) hs_cyc_q.push_back(cyc);
      if (core_rst) core_rst_cycles <= core_rst_cycles + 1;
      if (done) done_count <= done_count + 1;
      if (out_valid) out_valid_cycles <= out_valid_cycles + 1;
      if (dram_a2 != 32'd0) last_dram_a2 <= dram_a2;
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue_cmd(input logic op, input logic sel, input logic [12:0] count);
      int t = 0;
      while (!cmd_ready && t < 200) begin @(negedge CPU_CLK); t++; end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_count = count;
      @(negedge CPU_CLK);
      cmd_valid = 1'b0;
   endtask

   task automatic send_words(input wq_t w, input int gap_mode);
      foreach (w[k]) begin
         if (gap_mode == 1 || (gap_mode == 2 && ($urandom % 2) == 1)) begin
            in_valid = 1'b0; @(negedge CPU_CLK);
         end
         in_valid = 1'b1; in_data = w[k];
         for (int t = 0; t < 100 && !in_ready; t++) @(negedge CPU_CLK);
         @(negedge CPU_CLK);
      end
      in_valid = 1'b0;
   endtask

   task automatic recv_words(input int n, input int bp_mode, output wq_t got);
      int budget = (bp_mode == 0) ? n * 4 + 50 : n * 12 + 100;
      got = {};
      for (int t = 0; t < budget && got.size() < n; t++) begin
         out_ready = (bp_mode == 0) ? 1'b1 : 1'($urandom % 2);
         if (out_valid && out_ready) got.push_back(out_data);
         @(negedge CPU_CLK);
      end
      out_ready = 1'b0;
   endtask

   task automatic wait_done(input int start);
      for (int t = 0; t < 100 && done_count == start; t++) @(negedge CPU_CLK);
      @(negedge CPU_CLK);
   endtask

   task automatic preload_iram(input int idx, input logic [31:0] data);
      pre_we = 1'b1; pre_idx = 12'(idx); pre_data = data;
      @(negedge CPU_CLK);
      pre_we = 1'b0;
      exp_iram[idx] = data;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      CPU_RST = 1'b1; init_go = 1'b1;
      @(negedge CPU_CLK);
      init_go = 1'b0;
      for (int i = 0; i < 4096; i++) begin
         exp_dram[i] = 32'hD000_0000 | i;
         exp_iram[i] = 32'h1000_0000 | i;
      end
      @(negedge CPU_CLK);
      checks++;
      if ({cmd_ready, busy, core_hold, core_rst, done, in_ready, out_valid} !== 7'b1000000) begin
         errors++; $display("FAIL reset_ctrl: got %b required 1000000",
                            {cmd_ready, busy, core_hold, core_rst, done, in_ready, out_valid});
      end
      checks++;
      if ({out_data, dram_a2, dram_wd2, dram_we2, iram_a2, iram_wd2, iram_we2} !== 200'd0) begin
         errors++; $display("FAIL reset_data: out_data=%h dram_a2=%h dram_we2=%h iram_a2=%h iram_we2=%h required all 0",
                            out_data, dram_a2, dram_we2, iram_a2, iram_we2);
      end
      CPU_RST = 1'b0;
      @(negedge CPU_CLK);
      checks++;
      if ({cmd_ready, busy, core_hold} !== 3'b100) begin
         errors++; $display("FAIL reset_idle: ready/busy/hold=%b required 100", {cmd_ready, busy, core_hold});
      end
   endtask

   task automatic test_load_data();
      wq_t w = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
      int d0 = dram_wr_q.size(), i0 = iram_wr_q.size(), cr0 = core_rst_cycles, dn0 = done_count;
      issue_cmd(1'b0, 1'b0, 13'd3);
      send_words(w, 0);
      wait_done(dn0);
      checks++;
      if (dram_wr_q.size() - d0 !== 3) begin
         errors++; $display("FAIL load_wr_count: got %0d required 3", dram_wr_q.size() - d0);
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (dram_wr_q[d0+k].a !== 32'(4*k) || dram_wr_q[d0+k].d !== w[k]) begin
               errors++; $display("FAIL load_wr%0d: a2=%h wd2=%h required a2=%h wd2=%h",
                                  k, dram_wr_q[d0+k].a, dram_wr_q[d0+k].d, 32'(4*k), w[k]);
            end
            exp_dram[k] = w[k];
         end
      end
      checks++;
      if (iram_wr_q.size() !== i0) begin
         errors++; $display("FAIL load_iram_quiet: writes=%0d required 0", iram_wr_q.size() - i0);
      end
      checks++;
      if (core_rst_cycles - cr0 !== 5) begin
         errors++; $display("FAIL load_core_rst_len: got %0d required 5", core_rst_cycles - cr0);
      end
      checks++;
      if (done_count - dn0 !== 1) begin
         errors++; $display("FAIL load_done: pulses=%0d required 1", done_count - dn0);
      end
      checks++;
      if ({core_hold, cmd_ready, busy} !== 3'b010) begin
         errors++; $display("FAIL load_idle_after: hold/ready/busy=%b required 010", {core_hold, cmd_ready, busy});
      end
   endtask

   task automatic test_dump_backpressure();
      int d0, i0, cr0, dn0;
      preload_iram(0, 32'hDEAD_BEEF);
      preload_iram(1, 32'h00C0_FFEE);
      d0 = dram_wr_q.size(); i0 = iram_wr_q.size(); cr0 = core_rst_cycles; dn0 = done_count;
      issue_cmd(1'b1, 1'b1, 13'd2);
      out_ready = 1'b0;
      for (int t = 0; t < 20 && !out_valid; t++) @(negedge CPU_CLK);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL dump_hold%0d: valid=%b data=%h required 1 deadbeef", k, out_valid, out_data);
         end
         @(negedge CPU_CLK);
      end
      out_ready = 1'b1;
      @(negedge CPU_CLK);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL dump_valid_drop: out_valid=%b required 0", out_valid);
      end
      for (int t = 0; t < 20 && !out_valid; t++) @(negedge CPU_CLK);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h00C0_FFEE) begin
         errors++; $display("FAIL dump_word2: valid=%b data=%h required 1 00c0ffee", out_valid, out_data);
      end
      checks++;
      if (done_count !== dn0) begin
         errors++; $display("FAIL dump_early_done: pulses=%0d required 0", done_count - dn0);
      end
      @(negedge CPU_CLK);
      out_ready = 1'b0;
      wait_done(dn0);
      checks++;
      if (done_count - dn0 !== 1) begin
         errors++; $display("FAIL dump_done: pulses=%0d required 1", done_count - dn0);
      end
      checks++;
      if (dram_wr_q.size() != d0 || iram_wr_q.size() != i0 || core_rst_cycles != cr0) begin
         errors++; $display("FAIL dump_no_side_effects: dwr=%0d iwr=%0d core_rst=%0d required 0 0 0",
                            dram_wr_q.size() - d0, iram_wr_q.size() - i0, core_rst_cycles - cr0);
      end
   endtask

   task automatic test_count_clamp();
      wq_t got;
      int bad = 0, first_bad = -1;
      int dn0 = done_count;
      issue_cmd(1'b1, 1'b0, 13'd0);
      recv_words(4096, 0, got);
      checks++;
      if (got.size() !== 4096) begin
         errors++; $display("FAIL clamp_count: words=%0d required 4096", got.size());
      end
      foreach (got[i]) if (got[i] !== exp_dram[i]) begin bad++; if (first_bad < 0) first_bad = i; end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL clamp_data: %0d bad words, first at %0d got %h required %h",
                            bad, first_bad, got[first_bad], exp_dram[first_bad]);
      end
      wait_done(dn0);
      checks++;
      if (done_count - dn0 !== 1 || last_dram_a2 !== 32'h3FFC) begin
         errors++; $display("FAIL clamp_end: done=%0d last_a2=%h required 1 3ffc", done_count - dn0, last_dram_a2);
      end
      checks++;
      if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL clamp_idle: out_valid=%b cmd_ready=%b required 0 1", out_valid, cmd_ready);
      end
   endtask

   task automatic test_reset_mid_load();
      wq_t w = '{$urandom, $urandom, $urandom, $urandom};
      wq_t w01 = '{w[0], w[1]};
      wq_t w23 = '{w[2], w[3]};
      int d0 = dram_wr_q.size(), cr0 = core_rst_cycles, dn0 = done_count;
      issue_cmd(1'b0, 1'b0, 13'd5);
      send_words(w01, 0);
      CPU_RST = 1'b1;
      @(negedge CPU_CLK);
      checks++;
      if ({dram_we2, iram_we2} !== 8'h00 || {cmd_ready, busy, core_hold, in_ready} !== 4'b1000) begin
         errors++; $display("FAIL rst_mid_state: we2=%h ready/busy/hold/in_ready=%b required 00 1000",
                            {dram_we2, iram_we2}, {cmd_ready, busy, core_hold, in_ready});
      end
      CPU_RST = 1'b0;
      repeat (8) @(negedge CPU_CLK);
      checks++;
      if (done_count !== dn0 || core_rst_cycles !== cr0) begin
         errors++; $display("FAIL rst_mid_no_done: done=%0d core_rst=%0d required 0 0",
                            done_count - dn0, core_rst_cycles - cr0);
      end
      checks++;
      if (dram_wr_q.size() - d0 !== 2) begin
         errors++; $display("FAIL rst_mid_writes: got %0d required 2", dram_wr_q.size() - d0);
      end
      exp_dram[0] = w[0]; exp_dram[1] = w[1];
      d0 = dram_wr_q.size();
      issue_cmd(1'b0, 1'b0, 13'd2);
      send_words(w23, 0);
      wait_done(dn0);
      checks++;
      if (dram_wr_q.size() - d0 !== 2) begin
         errors++; $display("FAIL rst_restart_count: got %0d required 2", dram_wr_q.size() - d0);
      end else if (dram_wr_q[d0].a !== 32'd0 || dram_wr_q[d0].d !== w[2] || dram_wr_q[d0+1].a !== 32'd4) begin
         errors++; $display("FAIL rst_restart_addr: a2=%h wd2=%h next a2=%h required 0 %h 4",
                            dram_wr_q[d0].a, dram_wr_q[d0].d, dram_wr_q[d0+1].a, w[2]);
      end
      exp_dram[0] = w[2]; exp_dram[1] = w[3];
   endtask

   task automatic test_stalls_busy();
      wq_t w = '{$urandom, $urandom, $urandom, $urandom};
      int d0 = dram_wr_q.size(), i0 = iram_wr_q.size(), h0 = hs_cyc_q.size();
      int cr0 = core_rst_cycles, dn0 = done_count, ov0 = out_valid_cycles;
      issue_cmd(1'b0, 1'b1, 13'd4);
      foreach (w[k]) begin
         in_valid = 1'b0; @(negedge CPU_CLK);
         in_valid = 1'b1; in_data = w[k];
         if (k == 1) begin
            cmd_valid = 1'b1; cmd_op = 1'b1; cmd_sel = 1'b0; cmd_count = 13'd1;
            checks++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
               errors++; $display("FAIL busy_flags: cmd_ready=%b busy=%b required 0 1", cmd_ready, busy);
            end
         end
         for (int t = 0; t < 100 && !in_ready; t++) @(negedge CPU_CLK);
         @(negedge CPU_CLK);
         cmd_valid = 1'b0;
      end
      in_valid = 1'b0;
      wait_done(dn0);
      checks++;
      if (iram_wr_q.size() - i0 !== 4 || hs_cyc_q.size() - h0 !== 4) begin
         errors++; $display("FAIL stall_counts: writes=%0d handshakes=%0d required 4 4",
                            iram_wr_q.size() - i0, hs_cyc_q.size() - h0);
      end else begin
         foreach (w[k]) begin
            checks++;
            if (iram_wr_q[i0+k].a !== 32'(4*k) || iram_wr_q[i0+k].d !== w[k] ||
                iram_wr_q[i0+k].cyc !== hs_cyc_q[h0+k] + 32'd1) begin
               errors++; $display("FAIL stall_wr%0d: a2=%h wd2=%h cyc=%0d required %h %h %0d", k,
                                  iram_wr_q[i0+k].a, iram_wr_q[i0+k].d, iram_wr_q[i0+k].cyc,
                                  32'(4*k), w[k], hs_cyc_q[h0+k] + 32'd1);
            end
            exp_iram[k] = w[k];
         end
      end
      checks++;
      if (dram_wr_q.size() != d0 || out_valid_cycles != ov0 || done_count - dn0 != 1 || core_rst_cycles - cr0 != 5) begin
         errors++; $display("FAIL busy_ignored: dwr=%0d out_valid=%0d done=%0d core_rst=%0d required 0 0 1 5",
                            dram_wr_q.size() - d0, out_valid_cycles - ov0, done_count - dn0, core_rst_cycles - cr0);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 10; it++) begin
         logic op = 1'($urandom % 2);
         logic sel = 1'($urandom % 2);
         int n = 1 + int'($urandom % 6);
         int d0 = dram_wr_q.size(), i0 = iram_wr_q.size(), cr0 = core_rst_cycles, dn0 = done_count;
         wq_t w, got;
         int bad = 0;
         issue_cmd(op, sel, 13'(n));
         if (op == 1'b0) begin
            for (int k = 0; k < n; k++) w.push_back($urandom);
            send_words(w, 2);
            wait_done(dn0);
            checks++;
            if ((sel ? iram_wr_q.size() - i0 : dram_wr_q.size() - d0) !== n ||
                (sel ? dram_wr_q.size() - d0 : iram_wr_q.size() - i0) !== 0) begin
               errors++; $display("FAIL rnd%0d_load_count: dwr=%0d iwr=%0d required %0d on sel %0d",
                                  it, dram_wr_q.size() - d0, iram_wr_q.size() - i0, n, sel);
            end else begin
               for (int k = 0; k < n; k++) begin
                  wr_t e = sel ? iram_wr_q[i0+k] : dram_wr_q[d0+k];
                  if (e.a !== 32'(4*k) || e.d !== w[k]) bad++;
               end
               checks++;
               if (bad !== 0) begin
                  errors++; $display("FAIL rnd%0d_load_data: %0d bad writes required 0", it, bad);
               end
            end
            for (int k = 0; k < n; k++) if (sel) exp_iram[k] = w[k]; else exp_dram[k] = w[k];
            checks++;
            if (core_rst_cycles - cr0 !== 5) begin
               errors++; $display("FAIL rnd%0d_core_rst: got %0d required 5", it, core_rst_cycles - cr0);
            end
         end else begin
            recv_words(n, 1, got);
            wait_done(dn0);
            checks++;
            if (got.size() !== n) begin
               errors++; $display("FAIL rnd%0d_dump_count: got %0d required %0d", it, got.size(), n);
            end
            foreach (got[k]) if (got[k] !== (sel ? exp_iram[k] : exp_dram[k])) bad++;
            checks++;
            if (bad !== 0 || core_rst_cycles !== cr0) begin
               errors++; $display("FAIL rnd%0d_dump_data: bad=%0d core_rst=%0d required 0 0",
                                  it, bad, core_rst_cycles - cr0);
            end
         end
         checks++;
         if (done_count - dn0 !== 1) begin
            errors++; $display("FAIL rnd%0d_done: pulses=%0d required 1", it, done_count - dn0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_data();
      test_dump_backpressure();
      test_count_clamp();
      test_reset_mid_load();
      test_stalls_busy();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_debug_sequencer.md
Name: bram_debug_sequencer

Overview:
- Hardware sequencer for the RV32Core debug BRAM ports (`*_A2`, `*_WD2`, `*_WE2`, `*_RD2`).
- Loads a 32-bit word stream into the Data or Inst BRAM, or dumps BRAM contents out as a word stream.
- Holds the core idle while it owns the port, then issues a clean core reset pulse after a load.
- Sits between a host link (UART/JTAG bridge) and RV32Core. It replaces bench-driven port wiggling on the FPGA.

Parameters:
- BRAMWORDS, 4096: BRAM depth in 32-bit words.
- CNT_W, 13: width of the word count; equals clog2(BRAMWORDS)+1.
- RST_CYCLES, 5: length of the core reset pulse after a load completes.

Ports:
- CPU_CLK  in  1  single clock for all logic
- CPU_RST  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0=load, 1=dump
- cmd_sel  in  1  0=Data BRAM, 1=Inst BRAM
- cmd_count  in  CNT_W  number of words
- in_valid  in  1  load word valid
- in_ready  out  1  load word accepted
- in_data  in  32  load word
- out_valid  out  1  dump word valid
- out_ready  in  1  downstream accepts dump word
- out_data  out  32  dump word
- dram_a2  out  32  Data BRAM debug byte address
- dram_wd2  out  32  Data BRAM debug write data
- dram_we2  out  4  Data BRAM debug byte write enables
- dram_rd2  in  32  Data BRAM debug read data
- iram_a2, iram_wd2, iram_we2, iram_rd2: same four signals for Inst BRAM
- core_hold  out  1  high in every non-IDLE state
- core_rst  out  1  drives RV32Core CPU_RST after a load
- busy  out  1  equals ~cmd_ready
- done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1. State=IDLE, addr=0, cnt=0.
- Reset mid-operation: next edge forces IDLE with we2=0.
  - No partial write is repeated.
  - No done pulse is issued.
  - An in-flight out word is dropped.
- States: IDLE, LOAD, DUMP_RD, DUMP_WAIT, DUMP_OUT, CORE_RST.
- IDLE:
  - cmd_valid&cmd_ready accepts the command; addr←0.
  - cnt←cmd_count, clamped to BRAMWORDS if 0 or >BRAMWORDS.
  - Target latched from cmd_sel. Next state is LOAD (op=0) or DUMP_RD (op=1).
- LOAD:
  - in_ready=1; each in_valid&in_ready handshake consumes one word.
  - The cycle after the handshake (registered), the selected RAM sees a2=addr, wd2=word, we2=4'b1111 for exactly one cycle. we2=0 otherwise.
  - addr+=4 and cnt-=1 per handshake; in_valid gaps simply stall.
  - The handshake that takes cnt to 0 moves to CORE_RST. in_ready drops the same edge.
- CORE_RST: core_rst=1 for RST_CYCLES cycles, then done pulse and IDLE.
- DUMP_RD: a2=addr, we2=0. Next state DUMP_WAIT, covering the 1-cycle BRAM read latency.
- DUMP_WAIT: rd2 is captured into out_data. Next state DUMP_OUT.
- DUMP_OUT:
  - out_valid=1; out_data is held stable until out_ready.
  - On handshake: addr+=4, cnt-=1. If cnt reaches 0: done pulse and IDLE, else DUMP_RD.
  - Peak rate is one word per 3 cycles.
- The non-selected RAM port is driven a2=0, wd2=0, we2=0 at all times.
- core_rst=0 in all states except CORE_RST. A dump never resets the core.
- Address stays ≤ (BRAMWORDS-1)*4 by the clamp; no wrap occurs.
- cmd_valid while busy is not accepted and has no effect. in_valid outside LOAD is ignored (in_ready=0).
- done and cmd_ready rise on the same edge as the return to IDLE. A new command is accepted the following cycle.

Test Plan:
- Load to Data: cmd(op=0,sel=0,count=3), words 0x11111111, 0x22222222, 0x33333333 back-to-back.
  - Required: dram we2=F at a2=0,4,8 with matching wd2.
  - Required: iram we2 stays 0; core_rst high 5 cycles; done pulse; core_hold low after.
- Dump from Inst with backpressure: preload iram[0]=0xDEADBEEF, iram[1]=0x00C0FFEE; cmd(op=1,sel=1,count=2); out_ready low for 4 cycles.
  - Required: out_data holds 0xDEADBEEF stable, then 0x00C0FFEE; done after the 2nd handshake; no we2 activity.
- Count clamp: cmd(op=1,count=0).
  - Required: exactly 4096 out words; last a2=0x3FFC; done.
- Reset mid-load: after 2 of 5 words, assert CPU_RST for 1 cycle.
  - Required: we2=0, state IDLE, cmd_ready=1, no done, core_rst never asserted.
  - Required: a new load restarts at a2=0.
- Stalls and busy commands: in_valid toggling every other cycle, plus cmd_valid pulsed during LOAD.
  - Required: writes occur only after handshakes; the busy command is ignored; the original load completes normally.
